// File: rtl/icache_ctrl_if.sv
// Fetch-side and refill-side signal bundle for the instruction cache controller.
// The slave modport is the cache's view; the master modport is the pipeline/memory view.
interface icache_ctrl_if;
    logic [31:0]  Instr_address_2IM;
    logic         fetch_req;
    logic         flush;
    logic [255:0] block_read_fIM;
    logic         block_ready_fIM;
    logic [31:0]  Instr1_fIM;
    logic [31:0]  Instr2_fIM;
    logic         single_fetch;
    logic         FREEZE;
    logic         iBlkRead;
    logic [31:0]  iBlk_address;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    modport slave (
        input  Instr_address_2IM, fetch_req, flush, block_read_fIM, block_ready_fIM,
        output Instr1_fIM, Instr2_fIM, single_fetch, FREEZE, iBlkRead, iBlk_address,
               hit_count, miss_count
    );

    modport master (
        output Instr_address_2IM, fetch_req, flush, block_read_fIM, block_ready_fIM,
        input  Instr1_fIM, Instr2_fIM, single_fetch, FREEZE, iBlkRead, iBlk_address,
               hit_count, miss_count
    );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller with 256-bit lines, dual-instruction
// fetch on hit, and a three-state refill FSM (IDLE -> FILL -> RESP).
module icache_ctrl #(
    parameter int NUM_LINES = 16
) (
    input  logic         CLK,
    input  logic         RESET,
    icache_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 27 - IDX_W;

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

    state_t               state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [31:0]          blk_addr_q, blk_addr_d;
    logic [31:0]          hit_count_q, hit_count_d;
    logic [31:0]          miss_count_q, miss_count_d;
    logic                 flush_seen_q, flush_seen_d;

    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [255:0]         data_mem [NUM_LINES];

    logic [IDX_W-1:0]     req_idx, fill_idx;
    logic [TAG_W-1:0]     req_tag, fill_tag, rd_tag;
    logic [2:0]           req_word, nxt_word;
    logic [255:0]         rd_line;
    logic                 hit, fill_we, line_ok;
    logic                 unused_addr_bits;

    assign req_idx  = bus.Instr_address_2IM[5 +: IDX_W];
    assign req_tag  = bus.Instr_address_2IM[31 -: TAG_W];
    assign req_word = bus.Instr_address_2IM[4:2];
    assign nxt_word = req_word + 3'd1;
    assign fill_idx = blk_addr_q[5 +: IDX_W];
    assign fill_tag = blk_addr_q[31 -: TAG_W];
    assign unused_addr_bits = ^bus.Instr_address_2IM[1:0];

    // Asynchronous array read: hit data must be returned in the request cycle.
    assign rd_line = data_mem[req_idx];
    assign rd_tag  = tag_mem[req_idx];

    assign hit     = !RESET && bus.fetch_req && (state_q == IDLE)
                     && valid_q[req_idx] && (rd_tag == req_tag);
    assign fill_we = !RESET && (state_q == FILL) && bus.block_ready_fIM;
    // A flush seen at any point of the refill keeps the refilled line invalid.
    assign line_ok = !(bus.flush || flush_seen_q);

    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_valid
            assign valid_d[gi] = bus.flush ? 1'b0 :
                                 (fill_we && (fill_idx == IDX_W'(gi))) ? line_ok :
                                 valid_q[gi];
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        blk_addr_d   = blk_addr_q;
        flush_seen_d = flush_seen_q;
        hit_count_d  = hit_count_q + 32'(hit);
        miss_count_d = miss_count_q;
        case (state_q)
            IDLE: begin
                if (bus.fetch_req && !hit) begin
                    state_d      = FILL;
                    blk_addr_d   = {bus.Instr_address_2IM[31:5], 5'b0};
                    flush_seen_d = 1'b0;
                    miss_count_d = miss_count_q + 32'd1;
                end
            end
            FILL: begin
                if (bus.flush) begin
                    flush_seen_d = 1'b1;
                end
                if (bus.block_ready_fIM) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            blk_addr_q   <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            flush_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            blk_addr_q   <= blk_addr_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            flush_seen_q <= flush_seen_d;
        end
    end

    // Tag and data storage carry no reset; validity alone qualifies them.
    always_ff @(posedge CLK) begin
        if (fill_we) begin
            data_mem[fill_idx] <= bus.block_read_fIM;
            tag_mem[fill_idx]  <= fill_tag;
        end
    end

    assign bus.Instr1_fIM   = hit ? rd_line[{req_word, 5'b0} +: 32] : 32'd0;
    assign bus.Instr2_fIM   = (hit && (req_word != 3'd7)) ? rd_line[{nxt_word, 5'b0} +: 32] : 32'd0;
    assign bus.single_fetch = hit && (req_word == 3'd7);
    assign bus.FREEZE       = !RESET && ((state_q != IDLE) || (bus.fetch_req && !hit));
    assign bus.iBlkRead     = !RESET && (state_q == FILL);
    assign bus.iBlk_address = blk_addr_q;
    assign bus.hit_count    = hit_count_q;
    assign bus.miss_count   = miss_count_q;
endmodule
